// File: rtl/hrange_sum_pkg.sv
// ============================================================================
// hrange_sum_pkg : shared state encoding, default width and range test helper
// Revision 1.0
// ============================================================================
`default_nettype none

package hrange_sum_pkg;

  localparam int unsigned HR_WIDTH = 32;

  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_DRAIN_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_DRAIN = ST_DRAIN_ENC
  } gen_state_e;

  // Value is one bit wider than the range bounds so stepping past the
  // largest representable value cannot wrap back into the range.
  function automatic logic in_range(
    input logic signed [HR_WIDTH:0]   val,
    input logic signed [HR_WIDTH-1:0] lim,
    input logic signed [HR_WIDTH-1:0] stp
  );
    logic r;
    r = 1'b0;
    if (stp > 0)
      r = (val < lim);
    else if (stp < 0)
      r = (val > lim);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hrange_sum_hrange.sv
// ============================================================================
// hrange : range generator (base, limit, step) with start/ready/valid/done
// Revision 1.0
// ============================================================================
`default_nettype none

module hrange
  import hrange_sum_pkg::*;
#(
  parameter int WIDTH = HR_WIDTH
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic                    _start,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0
);

  gen_state_e state_q, state_d;
  logic done_q, done_d;
  logic valid_q, valid_d;
  logic signed [WIDTH-1:0] cur_q, cur_d;
  logic signed [WIDTH-1:0] limit_q, limit_d;
  logic signed [WIDTH-1:0] step_q, step_d;
  logic signed [WIDTH:0]   next_ext;

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    valid_d  = valid_q;
    cur_d    = cur_q;
    limit_d  = limit_q;
    step_d   = step_q;
    next_ext = {cur_q[WIDTH-1], cur_q} + {step_q[WIDTH-1], step_q};

    if (_start) begin
      cur_d   = base;
      limit_d = limit;
      step_d  = step;
      if (in_range({base[WIDTH-1], base}, limit, step)) begin
        valid_d = 1'b1;
        state_d = ST_RUN;
      end else begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end else if (state_q == ST_RUN && valid_q && _ready) begin
      if (in_range(next_ext, limit_q, step_q)) begin
        cur_d = next_ext[WIDTH-1:0];
      end else begin
        valid_d = 1'b0;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge _clock) begin
    if (_reset) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  // Valid and data deliberately survive reset; the consumer gates on state.
  always_ff @(posedge _clock) begin
    valid_q <= valid_d;
    cur_q   <= cur_d;
    limit_q <= limit_d;
    step_q  <= step_d;
  end

  assign _valid = valid_q;
  assign _done  = done_q;
  assign _0     = cur_q;

endmodule

`default_nettype wire

// File: rtl/hrange_sum.sv
// ============================================================================
// hrange_sum : yields each hrange item together with its running total
// Revision 1.0
// ============================================================================
`default_nettype none

module hrange_sum
  import hrange_sum_pkg::*;
#(
  parameter int WIDTH = HR_WIDTH
) (
  input  logic                    _clock,
  input  logic                    _reset,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic                    _start,
  input  logic                    _ready,
  output logic                    _valid,
  output logic                    _done,
  output logic signed [WIDTH-1:0] _0,
  output logic signed [WIDTH-1:0] _1
);

  gen_state_e state_q, state_d;
  logic valid_q, valid_d;
  logic done_q, done_d;
  logic signed [WIDTH-1:0] out0_q, out0_d;
  logic signed [WIDTH-1:0] out1_q, out1_d;
  logic signed [WIDTH-1:0] acc_q, acc_d;
  logic signed [WIDTH-1:0] sum;

  logic                    child_ready;
  logic                    child_valid;
  logic                    child_done;
  logic signed [WIDTH-1:0] child_0;

  hrange #(.WIDTH(WIDTH)) u_hrange (
    ._clock (_clock),
    ._reset (_reset),
    .base   (base),
    .limit  (limit),
    .step   (step),
    ._start (_start),
    ._ready (child_ready),
    ._valid (child_valid),
    ._done  (child_done),
    ._0     (child_0)
  );

  assign child_ready = (state_q == ST_RUN) && (!valid_q || _ready);
  assign sum         = acc_q + child_0;

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    out0_d  = out0_q;
    out1_d  = out1_q;
    acc_d   = acc_q;

    if (_start) begin
      acc_d   = '0;
      valid_d = 1'b0;
      state_d = ST_RUN;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (valid_q && _ready)
            valid_d = 1'b0;
          if (child_valid && child_ready) begin
            out0_d  = child_0;
            out1_d  = sum;
            acc_d   = sum;
            valid_d = 1'b1;
          end else if (child_done) begin
            if (!valid_q || _ready) begin
              done_d  = 1'b1;
              valid_d = 1'b0;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (_ready) begin
            done_d  = 1'b1;
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge _clock or posedge _reset) begin
    if (_reset) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      out0_q  <= '0;
      out1_q  <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      out0_q  <= out0_d;
      out1_q  <= out1_d;
      acc_q   <= acc_d;
    end
  end

  assign _valid = valid_q;
  assign _done  = done_q;
  assign _0     = out0_q;
  assign _1     = out1_q;

endmodule

`default_nettype wire

// File: tb/tb_hrange_sum.sv
// ============================================================================
// tb_hrange_sum : scoreboard bench for hrange_sum
// Revision 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_hrange_sum;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  logic signed [W-1:0] base, limit, step;
  logic start, ready;
  logic valid, done;
  logic signed [W-1:0] o0, o1;

  always #5 clk = ~clk;

  hrange_sum #(.WIDTH(W)) dut (
    ._clock (clk),
    ._reset (rst),
    .base   (base),
    .limit  (limit),
    .step   (step),
    ._start (start),
    ._ready (ready),
    ._valid (valid),
    ._done  (done),
    ._0     (o0),
    ._1     (o1)
  );

  typedef struct packed {
    logic [W-1:0] i;
    logic [W-1:0] t;
  } tup_t;

  tup_t exp_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int done_cnt = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model: Python-style range with a 32-bit wrapping running total
  task automatic push_range(input logic signed [W-1:0] b, input logic signed [W-1:0] l,
                            input logic signed [W-1:0] s);
    longint       i;
    logic [W-1:0] tot;
    tup_t         t;
    i   = b;
    tot = '0;
    while ((s > 0 && i < l) || (s < 0 && i > l)) begin
      tot = tot + i[W-1:0];
      t.i = i[W-1:0];
      t.t = tot;
      exp_q.push_back(t);
      i = i + s;
    end
  endtask

  // Consumption happens at the next rising edge; ignore the start cycle,
  // whose in-flight tuple is discarded by the design.
  always @(negedge clk) begin
    if (!rst && !start) begin
      if (valid && ready) begin
        tup_t e;
        if (exp_q.size() == 0) begin
          check("unexpected_tuple", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("item", o0, e.i);
          check("total", o1, e.t);
        end
      end
      if (done) begin
        done_cnt++;
        check("done_pending", exp_q.size(), 32'd0);
        check("done_with_valid", {31'd0, valid}, 32'd0);
      end
    end
  end

  task automatic start_gen(input logic signed [W-1:0] b, input logic signed [W-1:0] l,
                           input logic signed [W-1:0] s);
    base  = b;
    limit = l;
    step  = s;
    start = 1'b1;
    exp_q.delete();
    push_range(b, l, s);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int d0;
    int c;
    d0 = done_cnt;
    c  = 0;
    while (done_cnt == d0 && c < budget) begin
      @(posedge clk);
      #1;
      c++;
    end
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_done_count"}, done_cnt - d0, 32'd1);
    check({tag, "_left"}, exp_q.size(), 32'd0);
    check({tag, "_valid_after"}, {31'd0, valid}, 32'd0);
  endtask

  initial begin
    int d0;
    int c;
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    base  = '0;
    limit = '0;
    step  = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_o0", o0, 32'd0);
    check("rst_o1", o1, 32'd0);

    // Basic stream with latency check
    ready = 1'b1;
    start_gen(0, 10, 2);
    check("basic_lat1_valid", {31'd0, valid}, 32'd0);
    @(posedge clk);
    #1;
    check("basic_lat2_valid", {31'd0, valid}, 32'd1);
    check("basic_lat2_o0", o0, 32'd0);
    wait_done("basic", 20);

    // Backpressure at first item and on the last item
    ready = 1'b0;
    start_gen(0, 10, 2);
    c = 0;
    while (!valid && c < 10) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("bp_first_valid", {31'd0, valid}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      check("bp_hold_o0", o0, 32'd0);
      check("bp_hold_o1", o1, 32'd0);
      if (k < 2) begin
        @(posedge clk);
        #1;
      end
    end
    ready = 1'b1;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (!(valid && o0 == 8) && c < 20);
    ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("bp_drain_o1", o1, 32'd20);
      check("bp_drain_done", {31'd0, done}, 32'd0);
      @(posedge clk);
      #1;
    end
    ready = 1'b1;
    wait_done("bp", 10);

    // Empty range: done exactly two cycles after start
    d0 = done_cnt;
    start_gen(5, 5, 1);
    check("empty_done_c1", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    check("empty_done_c2", {31'd0, done}, 32'd1);
    check("empty_valid_c2", {31'd0, valid}, 32'd0);
    @(posedge clk);
    #1;
    check("empty_done_c3", {31'd0, done}, 32'd0);
    check("empty_done_count", done_cnt - d0, 32'd1);

    // Negative values
    start_gen(-5, 0, 2);
    wait_done("neg", 20);

    // Restart mid-stream after two tuples
    start_gen(0, 10, 2);
    c = 0;
    while (exp_q.size() > 3 && c < 20) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("restart_consumed", exp_q.size(), 32'd3);
    start_gen(1, 4, 1);
    wait_done("restart", 20);

    // Asynchronous reset between edges
    start_gen(0, 10, 2);
    @(posedge clk);
    #1;
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, valid}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_o0", o0, 32'd0);
    check("arst_o1", o1, 32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    @(posedge clk);
    #1 rst = 1'b0;
    start_gen(0, 4, 1);
    wait_done("arst", 20);

    // Accumulator wrap
    start_gen(32'sh7FFFFF00, 32'sh7FFFFF03, 1);
    wait_done("ovf", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
